// File: rtl/csa_pkg.sv
// csa_pkg: shared types and elaboration helpers for the pipelined
// carry-select adder/subtractor.
package csa_pkg;

    // Per-stage control context. The data vectors travel next to it because
    // their widths depend on module parameters.
    typedef struct packed {
        logic valid;    // stage holds a live beat
        logic carry;    // carry into the lowest slice this stage resolves
        logic msb_cin;  // carry into the MSB, known once the top slice is resolved
    } csa_ctx_t;

    // Number of pipeline stages for a given slicing.
    function automatic int csa_num_stages(input int dw, input int bw, input int bps);
        return (bw * bps > 0) ? dw / (bw * bps) : 1;
    endfunction

    // True when the slicing tiles the operand width exactly.
    function automatic bit csa_cfg_ok(input int dw, input int bw, input int bps);
        return (bw >= 1) && (bps >= 1) && (dw > 0) && ((dw % (bw * bps)) == 0);
    endfunction

endpackage

// File: rtl/csa_stage.sv
// csa_stage: one pipeline stage of the carry-select adder. Registers the
// context handed over by the previous stage, then resolves BLOCKS_PER_STAGE
// slices from the registered carry and passes the result onward.
module csa_stage
    import csa_pkg::*;
#(
    parameter int DATA_WIDTH       = 16,
    parameter int BLOCK_WIDTH      = 4,
    parameter int BLOCKS_PER_STAGE = 1,
    parameter int STAGE_IDX        = 0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  csa_ctx_t              i_ctx,
    input  logic [DATA_WIDTH-1:0] i_sum,
    input  logic [DATA_WIDTH-1:0] i_a,
    input  logic [DATA_WIDTH-1:0] i_b,
    input  logic                  i_advance_next,
    output logic                  o_advance,
    output csa_ctx_t              o_ctx,
    output logic [DATA_WIDTH-1:0] o_sum,
    output logic [DATA_WIDTH-1:0] o_a,
    output logic [DATA_WIDTH-1:0] o_b
);

    localparam int  SW      = BLOCK_WIDTH * BLOCKS_PER_STAGE;
    localparam int  LO      = STAGE_IDX * SW;
    localparam bit  IS_LAST = (LO + SW) == DATA_WIDTH;

    csa_ctx_t              r_ctx;
    logic [DATA_WIDTH-1:0] r_sum;
    logic [DATA_WIDTH-1:0] r_a;
    logic [DATA_WIDTH-1:0] r_b;

    logic [BLOCKS_PER_STAGE:0] w_c;
    logic [SW-1:0]             w_slice_sum;

    // An empty stage can always take a beat; a full one only if it can hand
    // its beat on in the same cycle.
    assign o_advance = !r_ctx.valid || i_advance_next;

    // Stage register: capture the upstream context whenever this stage advances.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: data registers are reset too, so a stage never exposes stale
            // operands after reset; non-blocking assignments keep every stage
            // sampling its neighbour's pre-edge value.
            r_ctx <= '0;
            r_sum <= '0;
            r_a   <= '0;
            r_b   <= '0;
        end else if (o_advance) begin
            r_ctx <= i_ctx;
            r_sum <= i_sum;
            r_a   <= i_a;
            r_b   <= i_b;
        end
    end

    assign w_c[0] = r_ctx.carry;

    // Carry-select slices: both candidate sums are formed in parallel and the
    // incoming carry picks one; the chosen carry-out selects the next slice.
    for (genvar j = 0; j < BLOCKS_PER_STAGE; j++) begin : g_slice
        localparam int BASE = LO + j * BLOCK_WIDTH;
        logic [BLOCK_WIDTH:0] w_s0;
        logic [BLOCK_WIDTH:0] w_s1;

        assign w_s0 = {1'b0, r_a[BASE +: BLOCK_WIDTH]} + {1'b0, r_b[BASE +: BLOCK_WIDTH]};
        assign w_s1 = {1'b0, r_a[BASE +: BLOCK_WIDTH]} + {1'b0, r_b[BASE +: BLOCK_WIDTH]}
                    + {{BLOCK_WIDTH{1'b0}}, 1'b1};
        assign w_slice_sum[j*BLOCK_WIDTH +: BLOCK_WIDTH] =
            w_c[j] ? w_s1[BLOCK_WIDTH-1:0] : w_s0[BLOCK_WIDTH-1:0];
        assign w_c[j+1] = w_c[j] ? w_s1[BLOCK_WIDTH] : w_s0[BLOCK_WIDTH];
    end

    // Hand-over to the next stage: merge the resolved bits into the partial sum.
    always_comb begin
        // NOTE: every output gets a default before any conditional update, so
        // no path leaves a value unassigned and no latch is inferred.
        o_ctx       = r_ctx;
        o_ctx.carry = w_c[BLOCKS_PER_STAGE];
        if (IS_LAST) begin
            // Carry into the MSB recovered from the MSB's own sum bit.
            o_ctx.msb_cin = r_a[DATA_WIDTH-1] ^ r_b[DATA_WIDTH-1] ^ w_slice_sum[SW-1];
        end
        o_sum           = r_sum;
        o_sum[LO +: SW] = w_slice_sum;
        o_a             = r_a;
        o_b             = r_b;
    end

endmodule

// File: rtl/pipelined_csa_adder.sv
// pipelined_csa_adder: parametrised pipelined carry-select adder/subtractor
// with a valid/ready handshake and per-stage bubble collapsing.
// Optional feature: define CSA_SAT_EN to saturate the sum on signed overflow.
module pipelined_csa_adder
    import csa_pkg::*;
#(
    parameter int DATA_WIDTH       = 16,
    parameter int BLOCK_WIDTH      = 4,
    parameter int BLOCKS_PER_STAGE = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_a,
    input  logic [DATA_WIDTH-1:0] in_b,
    input  logic                  in_sub,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_sum,
    output logic                  out_cout,
    output logic                  out_ovf
);

    localparam bit CFG_OK     = csa_cfg_ok(DATA_WIDTH, BLOCK_WIDTH, BLOCKS_PER_STAGE);
    localparam int NUM_STAGES = csa_num_stages(DATA_WIDTH, BLOCK_WIDTH, BLOCKS_PER_STAGE);

    if (!CFG_OK) begin : g_cfg_error
        $error("pipelined_csa_adder: DATA_WIDTH must be a multiple of BLOCK_WIDTH*BLOCKS_PER_STAGE");
    end

    // Index k is the context entering stage k; index NUM_STAGES feeds the output register.
    csa_ctx_t              w_ctx [NUM_STAGES+1];
    logic [DATA_WIDTH-1:0] w_sum [NUM_STAGES+1];
    logic [DATA_WIDTH-1:0] w_a   [NUM_STAGES+1];
    logic [DATA_WIDTH-1:0] w_b   [NUM_STAGES+1];
    logic                  w_adv [NUM_STAGES+1];

    logic                  w_ovf;
    logic [DATA_WIDTH-1:0] w_sum_sel;

    logic                  r_out_valid;
    logic [DATA_WIDTH-1:0] r_out_sum;
    logic                  r_out_cout;
    logic                  r_out_ovf;

    // Subtraction is A + ~B + 1: invert B here and seed the carry with in_sub.
    assign w_ctx[0] = '{valid: in_valid, carry: in_sub, msb_cin: 1'b0};
    assign w_sum[0] = '0;
    assign w_a[0]   = in_a;
    assign w_b[0]   = in_sub ? ~in_b : in_b;

    for (genvar k = 0; k < NUM_STAGES; k++) begin : g_stage
        csa_stage #(
            .DATA_WIDTH      (DATA_WIDTH),
            .BLOCK_WIDTH     (BLOCK_WIDTH),
            .BLOCKS_PER_STAGE(BLOCKS_PER_STAGE),
            .STAGE_IDX       (k)
        ) u_stage (
            .clk           (clk),
            .rst_n         (rst_n),
            .i_ctx         (w_ctx[k]),
            .i_sum         (w_sum[k]),
            .i_a           (w_a[k]),
            .i_b           (w_b[k]),
            .i_advance_next(w_adv[k+1]),
            .o_advance     (w_adv[k]),
            .o_ctx         (w_ctx[k+1]),
            .o_sum         (w_sum[k+1]),
            .o_a           (w_a[k+1]),
            .o_b           (w_b[k+1])
        );
    end

    // The output register frees up when empty or when downstream drains it;
    // this ripples back through the stages to form in_ready.
    assign w_adv[NUM_STAGES] = !r_out_valid || out_ready;
    assign in_ready          = w_adv[0];

    assign w_ovf = w_ctx[NUM_STAGES].msb_cin ^ w_ctx[NUM_STAGES].carry;

`ifdef CSA_SAT_EN
    // Clamp toward the operands' common sign when the signed result overflows.
    always_comb begin
        w_sum_sel = w_sum[NUM_STAGES];
        if (w_ovf) begin
            w_sum_sel = w_a[NUM_STAGES][DATA_WIDTH-1] ? {1'b1, {(DATA_WIDTH-1){1'b0}}}
                                                      : {1'b0, {(DATA_WIDTH-1){1'b1}}};
        end
    end
`else
    assign w_sum_sel = w_sum[NUM_STAGES];
`endif

    // Output register: holds its beat while downstream stalls.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid <= 1'b0;
            r_out_sum   <= '0;
            r_out_cout  <= 1'b0;
            r_out_ovf   <= 1'b0;
        end else if (w_adv[NUM_STAGES]) begin
            r_out_valid <= w_ctx[NUM_STAGES].valid;
            r_out_sum   <= w_sum_sel;
            r_out_cout  <= w_ctx[NUM_STAGES].carry;
            r_out_ovf   <= w_ovf;
        end
    end

    assign out_valid = r_out_valid;
    assign out_sum   = r_out_sum;
    assign out_cout  = r_out_cout;
    assign out_ovf   = r_out_ovf;

endmodule

// File: tb/tb_pipelined_csa_adder.sv
// tb_pipelined_csa_adder: self-checking bench for pipelined_csa_adder.
// An arithmetic reference model predicts every result in input order; a
// negedge monitor compares handshake and data each cycle. Directed beats pin
// the model to hand-computed values. BW/BPS may be changed for other slicings.
`timescale 1ns/1ps
module tb_pipelined_csa_adder;

    localparam int DW  = 16;
    localparam int BW  = 4;
    localparam int BPS = 1;
    localparam int NS  = DW / (BW * BPS);

    localparam longint MAXS = (longint'(1) << (DW - 1)) - 1;
    localparam longint MINS = -(longint'(1) << (DW - 1));

`ifdef CSA_SAT_EN
    localparam logic [DW-1:0] OVF_ADD_SUM = 16'h7FFF;
    localparam logic [DW-1:0] OVF_SUB_SUM = 16'h8000;
`else
    localparam logic [DW-1:0] OVF_ADD_SUM = 16'h8000;
    localparam logic [DW-1:0] OVF_SUB_SUM = 16'h7FFF;
`endif

    typedef struct {
        logic [DW-1:0] sum;
        logic          cout;
        logic          ovf;
    } exp_t;

    logic          clk       = 1'b0;
    logic          rst_n     = 1'b0;
    logic          in_valid  = 1'b0;
    logic          in_sub    = 1'b0;
    logic          out_ready = 1'b0;
    logic [DW-1:0] in_a      = '0;
    logic [DW-1:0] in_b      = '0;
    logic          in_ready;
    logic          out_valid;
    logic          out_cout;
    logic          out_ovf;
    logic [DW-1:0] out_sum;

    int n_checks = 0;
    int n_errors = 0;

    exp_t          model_q[$];
    logic [DW-1:0] got_q[$];
    logic          stalled = 1'b0;
    exp_t          held;

    always #5 clk = ~clk;

    pipelined_csa_adder #(
        .DATA_WIDTH      (DW),
        .BLOCK_WIDTH     (BW),
        .BLOCKS_PER_STAGE(BPS)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_a     (in_a),
        .in_b     (in_b),
        .in_sub   (in_sub),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_sum  (out_sum),
        .out_cout (out_cout),
        .out_ovf  (out_ovf)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: integer arithmetic on the operands, no knowledge of slicing.
    function automatic exp_t model(input logic [DW-1:0] a, input logic [DW-1:0] b, input logic sub);
        exp_t   e;
        longint ua = longint'(a);
        longint ub = longint'(b);
        longint sa = longint'($signed(a));
        longint sb = longint'($signed(b));
        longint ures = sub ? ua - ub : ua + ub;
        longint sres = sub ? sa - sb : sa + sb;
        longint clamp;
        e.sum  = ures[DW-1:0];
        e.cout = sub ? (ua >= ub) : (ures >= (longint'(1) << DW));
        e.ovf  = (sres > MAXS) || (sres < MINS);
`ifdef CSA_SAT_EN
        clamp = (sres > 0) ? MAXS : MINS;
        if (e.ovf) e.sum = clamp[DW-1:0];
`else
        clamp = 0;
`endif
        return e;
    endfunction

    // Monitor: sample between edges; transfers seen here happen at the next posedge.
    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            model_q.delete();
            stalled = 1'b0;
            check("rst_out_valid", out_valid, 0);
            check("rst_out_sum", out_sum, 0);
            check("rst_out_cout", out_cout, 0);
            check("rst_out_ovf", out_ovf, 0);
        end else begin
            check("in_ready", in_ready, !((model_q.size() == NS + 1) && !out_ready));
            if (model_q.size() == 0) check("idle_out_valid", out_valid, 0);
            if (stalled) begin
                check("stall_valid", out_valid, 1);
                check("stall_sum", out_sum, held.sum);
                check("stall_cout", out_cout, held.cout);
                check("stall_ovf", out_ovf, held.ovf);
            end
            if (out_valid && out_ready && (model_q.size() > 0)) begin
                e = model_q.pop_front();
                check("out_sum", out_sum, e.sum);
                check("out_cout", out_cout, e.cout);
                check("out_ovf", out_ovf, e.ovf);
                got_q.push_back(out_sum);
            end
            stalled = out_valid && !out_ready;
            held    = '{sum: out_sum, cout: out_cout, ovf: out_ovf};
            if (in_valid && in_ready) model_q.push_back(model(in_a, in_b, in_sub));
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One beat into an empty pipeline with out_ready high; checks latency and literals.
    task automatic directed(input string name, input logic [DW-1:0] a, input logic [DW-1:0] b,
                            input logic sub, input logic [DW-1:0] es, input logic ec, input logic eo);
        int lat;
        out_ready = 1'b1;
        in_a      = a;
        in_b      = b;
        in_sub    = sub;
        in_valid  = 1'b1;
        step();
        in_valid = 1'b0;
        lat      = 0;
        while (!out_valid && lat < 64) begin
            step();
            lat++;
        end
        check({name, "_latency"}, lat, NS);
        check({name, "_sum"}, out_sum, es);
        check({name, "_cout"}, out_cout, ec);
        check({name, "_ovf"}, out_ovf, eo);
        step();
    endtask

    function automatic logic [DW-1:0] pick();
        logic [DW-1:0] v;
        case ($urandom_range(0, 7))
            0:       v = '0;
            1:       v = '1;
            2:       v = {1'b0, {(DW-1){1'b1}}};
            3:       v = {1'b1, {(DW-1){1'b0}}};
            default: v = DW'($urandom);
        endcase
        return v;
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int i;
        int cyc;
        int acc;

        // Reset state.
        repeat (3) step();
        check("reset_out_valid", out_valid, 0);
        check("reset_in_ready", in_ready, 1);
        rst_n = 1'b1;
        repeat (2) step();

        // Directed beats with hand-computed results.
        directed("carry_chain", 16'h00FF, 16'h0001, 1'b0, 16'h0100, 1'b0, 1'b0);
        directed("full_carry",  16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0);
        directed("add_ovf",     16'h7FFF, 16'h0001, 1'b0, OVF_ADD_SUM, 1'b0, 1'b1);
        directed("sub_neg",     16'h0005, 16'h0007, 1'b1, 16'hFFFE, 1'b0, 1'b0);
        directed("sub_ovf",     16'h8000, 16'h0001, 1'b1, OVF_SUB_SUM, 1'b1, 1'b1);

        // Back-pressure: 8 back-to-back beats, out_ready toggling every cycle.
        got_q.delete();
        i   = 0;
        cyc = 0;
        while ((i < 8 || got_q.size() < 8) && cyc < 300) begin
            out_ready = (cyc % 2 == 0);
            in_valid  = (i < 8);
            in_a      = DW'(i);
            in_b      = DW'(16 * i);
            in_sub    = 1'b0;
            @(negedge clk);
            if (in_valid && in_ready) i++;
            step();
            cyc++;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        check("bp_count", got_q.size(), 8);
        for (int k = 0; k < 8 && k < got_q.size(); k++) check("bp_order", got_q[k], 17 * k);
        repeat (NS + 2) step();

        // Reset mid-stream with beats in flight.
        out_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            in_valid = 1'b1;
            in_a     = DW'(k + 1);
            in_b     = DW'(3);
            in_sub   = 1'b0;
            step();
        end
        in_valid = 1'b0;
        repeat (NS + 1) step();
        check("pre_rst_valid", out_valid, 1);
        rst_n = 1'b0;
        #1;
        check("mid_rst_valid", out_valid, 0);
        check("mid_rst_sum", out_sum, 0);
        repeat (2) step();
        rst_n     = 1'b1;
        out_ready = 1'b1;
        repeat (NS + 4) step();
        check("post_rst_valid", out_valid, 0);

        // Random traffic under random valid/ready.
        acc = 0;
        cyc = 0;
        while (acc < 3000 && cyc < 20000) begin
            in_valid  = ($urandom_range(0, 9) < 7);
            out_ready = ($urandom_range(0, 9) < 6);
            in_a      = pick();
            in_b      = pick();
            in_sub    = 1'($urandom_range(0, 1));
            @(negedge clk);
            if (in_valid && in_ready) acc++;
            step();
            cyc++;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        check("rand_accepted", acc, 3000);
        cyc = 0;
        while (model_q.size() > 0 && cyc < 200) begin
            step();
            cyc++;
        end
        check("drain_empty", model_q.size(), 0);
        repeat (2) step();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
